sha_msg_arbiter: RTL and testbench
==================================

SHA_MSG_ARBITER -- requirements
Module: sha_msg_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of the stream data word.
REQ-002 SHALL have parameter USER_WIDTH, default 2, the width of the TUSER mode/padding tag.
REQ-003 SHALL have port ACLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port ARESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port S_TDATA  input  2xDATA_WIDTH  requester data, index 0/1.
REQ-006 SHALL have port S_TVALID  input  2  per-requester valid.
REQ-007 SHALL have port S_TLAST  input  2  per-requester last beat of message.
REQ-008 SHALL have port S_TUSER  input  2xUSER_WIDTH  per-requester mode tag.
REQ-009 SHALL have port S_TREADY  output  2  per-requester ready.
REQ-010 SHALL have port M_TDATA/M_TVALID/M_TLAST/M_TUSER  output  DATA_WIDTH/1/1/USER_WIDTH  stream to shared hash core.
REQ-011 SHALL have port M_TID  output  1  index of the requester owning the current beat.
REQ-012 SHALL have port M_TREADY  input  1  core accepts beat.
REQ-013 SHALL have port CORE_DONE  input  1  single-cycle pulse: digest of the last message ready.
REQ-014 SHALL have port DONE_ID  output  1  requester whose digest completed; valid with DONE_VALID.
REQ-015 SHALL have port DONE_VALID  output  1  registered one-cycle pulse, cycle after accepted CORE_DONE.
REQ-016 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-017 SHALL have port MSG_BEATS  output  16  beats accepted in current/last message, saturating at 0xFFFF.
REQ-018 SHALL have port ERR  output  1  sticky protocol-error flag.

Function
REQ-019 SHALL implement states IDLE, STREAM, WAIT_DIGEST.
REQ-020 IDLE: if any S_TVALID, register grant g and move to STREAM next cycle; all S_TREADY=0, M_TVALID=0 in IDLE.
REQ-021 Both S_TVALID in IDLE: grant requester not equal to last_winner (round-robin); single valid: grant it.
REQ-022 STREAM: M_TDATA/M_TVALID/M_TLAST/M_TUSER combinationally equal S_*[g]; M_TID=g; S_TREADY[g]=M_TREADY; S_TREADY[!g]=0.
REQ-023 Grant SHALL be held for the whole message; no switch before beat with M_TVALID&M_TREADY&M_TLAST.
REQ-024 Beat with M_TVALID&M_TREADY&M_TLAST SHALL move STREAM->WAIT_DIGEST next cycle.
REQ-025 WAIT_DIGEST: all S_TREADY=0, M_TVALID=0; CORE_DONE moves to IDLE, sets last_winner=g, pulses DONE_VALID with DONE_ID=g.
REQ-026 Latency: first beat transferable 1 cycle after S_TVALID seen in IDLE; next grant earliest cycle after CORE_DONE.
REQ-027 MSG_BEATS SHALL clear on grant in IDLE, increment per accepted beat in STREAM, saturate at 0xFFFF, hold otherwise.
REQ-028 CORE_DONE in IDLE or STREAM (including same cycle as TLAST beat) SHALL be ignored for state and set ERR.
REQ-029 ERR SHALL remain set until reset.
REQ-030 Grantee dropping S_TVALID mid-message SHALL not release grant.

Reset
REQ-031 ARESET SHALL immediately force state IDLE, last_winner=1 (requester 0 wins first tie), g=0.
REQ-032 Reset values: S_TREADY=0, M_TVALID=0, M_TLAST=0, M_TID=0, DONE_VALID=0, DONE_ID=0, BUSY=0, MSG_BEATS=0, ERR=0.
REQ-033 Reset mid-message SHALL discard message; no DONE_VALID generated for it.

Structure
REQ-034 Package sha_arb_pkg SHALL hold the state enum type and default DATA_WIDTH/USER_WIDTH constants.
REQ-035 Combinational 2-way round-robin pick SHALL be sub-module sha_rr_pick (inputs req[1:0], last_winner; output grant index, any).

Verification
REQ-036 Only S0 sends 3 beats 0x1111,0x2222,0x3333 (TLAST on 3rd), M_TREADY=1 -> M_TDATA same order, M_TID=0, MSG_BEATS=3, WAIT_DIGEST; CORE_DONE -> DONE_VALID, DONE_ID=0.
REQ-037 Both valid after reset -> S0 first; after its CORE_DONE, both valid again -> S1 granted; then S0.
REQ-038 S1 valid while S0 message in flight and in WAIT_DIGEST -> S_TREADY[1]=0 throughout; S1 granted 1 cycle after CORE_DONE.
REQ-039 M_TREADY toggling 1,0,1,0 during 4-beat message -> no beat lost or duplicated, MSG_BEATS=4.
REQ-040 CORE_DONE pulsed in IDLE -> ERR=1, state IDLE, no DONE_VALID; ERR stays 1 until ARESET.
REQ-041 ARESET asserted on 2nd beat of S0 message -> outputs at reset values same cycle; after release S1-only request granted normally.

Source files
------------

// File: rtl/sha_arb_pkg.sv
// Shared types and constants for the two-requester SHA message arbiter.
//   arb_state_t      : arbiter FSM states
//   DEF_DATA_WIDTH   : default stream data width
//   DEF_USER_WIDTH   : default TUSER (mode/padding tag) width
//   sat_inc16()      : 16-bit increment that sticks at all-ones
package sha_arb_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_USER_WIDTH = 2;

  localparam logic [15:0] BEATS_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_STREAM      = 2'd1,
    ST_WAIT_DIGEST = 2'd2
  } arb_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == BEATS_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sha_rr_pick.sv
// Combinational two-way round-robin picker.
//   req[1:0]    : request vector
//   last_winner : index granted most recently
//   grant       : chosen index (only meaningful when any=1)
//   any         : at least one request present
// With both requests present, the requester that did not win last time is
// chosen; with a single request, that requester is chosen.
module sha_rr_pick
  import sha_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_winner;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/sha_msg_arbiter.sv
// Arbitrates two AXI-Stream message sources onto one shared hash core.
// A grant is held for a whole message (through the TLAST beat), then the
// arbiter waits for the core's CORE_DONE before granting again.
//   ACLK, ARESET         : clock, asynchronous active-high reset
//   S_TDATA/TVALID/TLAST/TUSER/TREADY : two packed requester streams
//   M_TDATA/TVALID/TLAST/TUSER/TID/TREADY : stream to the hash core
//   CORE_DONE            : core pulse, digest of last message ready
//   DONE_VALID, DONE_ID  : registered completion pulse and its owner
//   BUSY                 : arbiter not idle
//   MSG_BEATS            : saturating beat count of current/last message
//   ERR                  : sticky flag, CORE_DONE seen outside WAIT_DIGEST
module sha_msg_arbiter
  import sha_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int USER_WIDTH = DEF_USER_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [2*DATA_WIDTH-1:0] S_TDATA,
  input  logic [1:0]              S_TVALID,
  input  logic [1:0]              S_TLAST,
  input  logic [2*USER_WIDTH-1:0] S_TUSER,
  output logic [1:0]              S_TREADY,
  output logic [DATA_WIDTH-1:0]   M_TDATA,
  output logic                    M_TVALID,
  output logic                    M_TLAST,
  output logic [USER_WIDTH-1:0]   M_TUSER,
  output logic                    M_TID,
  input  logic                    M_TREADY,
  input  logic                    CORE_DONE,
  output logic                    DONE_ID,
  output logic                    DONE_VALID,
  output logic                    BUSY,
  output logic [15:0]             MSG_BEATS,
  output logic                    ERR
);

  arb_state_t        state_reg;
  logic              grant_reg;
  logic              last_winner_reg;
  logic [15:0]       msg_beats_reg;
  logic              done_valid_reg;
  logic              done_id_reg;
  logic              err_reg;

  logic              pick_grant;
  logic              pick_any;
  logic              in_stream;
  logic              beat_fire;

  logic [DATA_WIDTH-1:0] s_data [2];
  logic [USER_WIDTH-1:0] s_user [2];

  assign in_stream = (state_reg == ST_STREAM);

  // Unpack the requester lanes and route TREADY only to the owner while
  // streaming; everything else sees back-pressure.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign s_data[gi]   = S_TDATA[gi*DATA_WIDTH +: DATA_WIDTH];
      assign s_user[gi]   = S_TUSER[gi*USER_WIDTH +: USER_WIDTH];
      assign S_TREADY[gi] = in_stream & (grant_reg == 1'(gi)) & M_TREADY;
    end
  endgenerate

  sha_rr_pick u_pick (
    .req         (S_TVALID),
    .last_winner (last_winner_reg),
    .grant       (pick_grant),
    .any         (pick_any)
  );

  // Master side is a straight pass-through of the owner lane, gated by
  // state so nothing leaks out while idle, waiting, or held in reset.
  assign M_TVALID   = in_stream & S_TVALID[grant_reg];
  assign M_TLAST    = in_stream & S_TLAST[grant_reg];
  assign M_TDATA    = in_stream ? s_data[grant_reg] : '0;
  assign M_TUSER    = in_stream ? s_user[grant_reg] : '0;
  assign M_TID      = grant_reg;
  assign beat_fire  = M_TVALID & M_TREADY;

  assign BUSY       = (state_reg != ST_IDLE);
  assign MSG_BEATS  = msg_beats_reg;
  assign DONE_VALID = done_valid_reg;
  assign DONE_ID    = done_id_reg;
  assign ERR        = err_reg;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= 1'b0;
      // Starting at 1 lets requester 0 win the first tie.
      last_winner_reg <= 1'b1;
      msg_beats_reg   <= 16'd0;
      done_valid_reg  <= 1'b0;
      done_id_reg     <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      done_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (CORE_DONE) begin
            err_reg <= 1'b1;
          end
          if (pick_any) begin
            grant_reg     <= pick_grant;
            msg_beats_reg <= 16'd0;
            state_reg     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // A digest cannot be ready before the message has ended, even
          // if it coincides with the TLAST beat.
          if (CORE_DONE) begin
            err_reg <= 1'b1;
          end
          if (beat_fire) begin
            msg_beats_reg <= sat_inc16(msg_beats_reg);
            if (M_TLAST) begin
              state_reg <= ST_WAIT_DIGEST;
            end
          end
        end
        ST_WAIT_DIGEST: begin
          if (CORE_DONE) begin
            state_reg       <= ST_IDLE;
            last_winner_reg <= grant_reg;
            done_valid_reg  <= 1'b1;
            done_id_reg     <= grant_reg;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_arbiter.sv
// Self-checking bench for sha_msg_arbiter: directed scenarios followed by a
// randomized run, all cycles compared against a transaction-level model.
module tb_sha_msg_arbiter;

  localparam int DW = 16;
  localparam int UW = 2;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b0;
  logic [2*DW-1:0] S_TDATA = '0;
  logic [1:0]      S_TVALID = '0;
  logic [1:0]      S_TLAST = '0;
  logic [2*UW-1:0] S_TUSER = '0;
  logic [1:0]      S_TREADY;
  logic [DW-1:0]   M_TDATA;
  logic            M_TVALID;
  logic            M_TLAST;
  logic [UW-1:0]   M_TUSER;
  logic            M_TID;
  logic            M_TREADY = 1'b0;
  logic            CORE_DONE = 1'b0;
  logic            DONE_ID;
  logic            DONE_VALID;
  logic            BUSY;
  logic [15:0]     MSG_BEATS;
  logic            ERR;

  sha_msg_arbiter #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST),
    .S_TUSER(S_TUSER), .S_TREADY(S_TREADY),
    .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TLAST(M_TLAST),
    .M_TUSER(M_TUSER), .M_TID(M_TID), .M_TREADY(M_TREADY),
    .CORE_DONE(CORE_DONE), .DONE_ID(DONE_ID), .DONE_VALID(DONE_VALID),
    .BUSY(BUSY), .MSG_BEATS(MSG_BEATS), .ERR(ERR)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- source queues and bench knobs ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t src_q0[$];
  beat_t src_q1[$];
  logic [DW:0] out_q[$];      // {tid, data} of every master-side beat
  logic        done_q[$];     // DONE_ID of every DONE_VALID pulse
  logic [1:0]  hs = '0;       // source handshakes seen in the last cycle
  int cyc = 0;
  int first1_cyc = -1;
  int first_done_cyc = -1;
  int rdy1_early = 0;
  int gap_pct = 0;
  int mrdy_mode = 0;          // 0: always ready, 1: random, 2: toggle
  int core_lat = 2;
  int done_wait = 0;
  bit core_auto = 1'b1;
  bit spur_done = 1'b0;

  // ---------------- reference model (message-level rules) ----------------
  int         m_phase = 0;    // 0 idle, 1 message streaming, 2 awaiting digest
  logic       m_owner = 1'b0;
  logic       m_last = 1'b1;
  logic       m_err = 1'b0;
  logic       m_done_v = 1'b0;
  logic       m_done_id = 1'b0;
  logic [15:0] m_beats = '0;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_phase <= 0; m_owner <= 1'b0; m_last <= 1'b1; m_err <= 1'b0;
      m_done_v <= 1'b0; m_done_id <= 1'b0; m_beats <= '0;
    end else begin
      m_done_v <= 1'b0;
      if (CORE_DONE && m_phase != 2) m_err <= 1'b1;
      if (m_phase == 0) begin
        if (S_TVALID != 2'b00) begin
          m_phase <= 1;
          m_beats <= '0;
          m_owner <= (S_TVALID == 2'b11) ? ~m_last : S_TVALID[1];
        end
      end else if (m_phase == 1) begin
        if (S_TVALID[m_owner] && M_TREADY) begin
          m_beats <= (m_beats == 16'hFFFF) ? m_beats : 16'(m_beats + 16'd1);
          if (S_TLAST[m_owner]) m_phase <= 2;
        end
      end else if (CORE_DONE) begin
        m_phase <= 0; m_last <= m_owner; m_done_v <= 1'b1; m_done_id <= m_owner;
      end
    end
  end

  logic       exp_mv;
  logic [1:0] exp_rdy;
  always_comb begin
    exp_mv  = (m_phase == 1) && S_TVALID[m_owner];
    exp_rdy = 2'b00;
    if (m_phase == 1 && M_TREADY) exp_rdy[m_owner] = 1'b1;
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge ACLK) begin
    check("busy", 32'(BUSY), 32'(m_phase != 0));
    check("s_tready", 32'(S_TREADY), 32'(exp_rdy));
    check("m_tvalid", 32'(M_TVALID), 32'(exp_mv));
    check("msg_beats", 32'(MSG_BEATS), 32'(m_beats));
    check("err", 32'(ERR), 32'(m_err));
    check("done_valid", 32'(DONE_VALID), 32'(m_done_v));
    if (m_done_v) check("done_id", 32'(DONE_ID), 32'(m_done_id));
    if (m_phase == 1) check("m_tid", 32'(M_TID), 32'(m_owner));
    if (exp_mv) begin
      check("m_tdata", 32'(M_TDATA), 32'(S_TDATA[int'(m_owner)*DW +: DW]));
      check("m_tuser", 32'(M_TUSER), 32'(S_TUSER[int'(m_owner)*UW +: UW]));
      check("m_tlast", 32'(M_TLAST), 32'(S_TLAST[m_owner]));
    end
  end

  // Event recorder.
  always @(negedge ACLK) begin
    hs = S_TVALID & S_TREADY;
    if (S_TREADY[1] && done_q.size() == 0) rdy1_early++;
    if (M_TVALID && M_TREADY) out_q.push_back({M_TID, M_TDATA});
    if (M_TVALID && M_TID && first1_cyc < 0) first1_cyc = cyc;
    if (CORE_DONE && first_done_cyc < 0) first_done_cyc = cyc;
    if (DONE_VALID) done_q.push_back(DONE_ID);
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_msg(input int i, input int len, input logic [DW-1:0] base,
                          input logic [DW-1:0] step);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'(base + DW'(k) * step);
      b.user = UW'($urandom);
      b.last = (k == len - 1);
      if (i == 0) src_q0.push_back(b); else src_q1.push_back(b);
    end
  endtask

  task automatic drive_src(input int i);
    beat_t b;
    logic  have;
    have = (i == 0) ? (src_q0.size() > 0) : (src_q1.size() > 0);
    b = '0;
    if (have) b = (i == 0) ? src_q0[0] : src_q1[0];
    S_TVALID[i] = have && !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
    S_TDATA[i*DW +: DW] = b.data;
    S_TUSER[i*UW +: UW] = b.user;
    S_TLAST[i] = b.last;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
    if (hs[0] && src_q0.size() > 0) void'(src_q0.pop_front());
    if (hs[1] && src_q1.size() > 0) void'(src_q1.pop_front());
    hs = 2'b00;
    drive_src(0);
    drive_src(1);
    case (mrdy_mode)
      1:       M_TREADY = ($urandom_range(0, 99) < 70);
      2:       M_TREADY = ~M_TREADY;
      default: M_TREADY = 1'b1;
    endcase
    CORE_DONE = 1'b0;
    if (spur_done) begin
      CORE_DONE = 1'b1;
      spur_done = 1'b0;
    end else if (core_auto && m_phase == 2) begin
      if (done_wait >= core_lat) CORE_DONE = 1'b1;
      else done_wait++;
    end else begin
      done_wait = 0;
    end
  endtask

  task automatic do_reset(input bit chk);
    ARESET = 1'b1;
    src_q0.delete(); src_q1.delete();
    S_TVALID = 2'b11; S_TLAST = 2'b11; M_TREADY = 1'b1; CORE_DONE = 1'b0;
    #2;
    if (chk) begin
      check("rst_s_tready", 32'(S_TREADY), 32'd0);
      check("rst_m_tvalid", 32'(M_TVALID), 32'd0);
      check("rst_m_tlast", 32'(M_TLAST), 32'd0);
      check("rst_m_tid", 32'(M_TID), 32'd0);
      check("rst_done_valid", 32'(DONE_VALID), 32'd0);
      check("rst_done_id", 32'(DONE_ID), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_msg_beats", 32'(MSG_BEATS), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
    end
    repeat (2) @(posedge ACLK);
    #1;
    S_TVALID = 2'b00; S_TLAST = 2'b00; M_TREADY = 1'b0;
    ARESET = 1'b0;
    spur_done = 1'b0; done_wait = 0; core_auto = 1'b1; core_lat = 2;
    gap_pct = 0; mrdy_mode = 0;
    out_q.delete(); done_q.delete(); hs = 2'b00;
    first1_cyc = -1; first_done_cyc = -1; rdy1_early = 0;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int c = 0;
    while (done_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(tag, 32'(done_q.size()), 32'(n));
  endtask

  task automatic check_out(input string tag, input int k, input logic tid, input logic [DW-1:0] d);
    logic [DW:0] e;
    e = '1;
    if (k < out_q.size()) e = out_q[k];
    check(tag, 32'(e), 32'({tid, d}));
  endtask

  task automatic check_done_id(input string tag, input int k, input logic id);
    logic v;
    v = 1'bx;
    if (k < done_q.size()) v = done_q[k];
    check(tag, 32'(v), 32'(id));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #3;
    // Single requester, three beats.
    do_reset(1);
    push_msg(0, 3, 16'h1111, 16'h1111);
    wait_done("t1_done_count", 1, 60);
    check("t1_out_count", 32'(out_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) check_out("t1_beat", k, 1'b0, DW'(16'h1111 * (k + 1)));
    check_done_id("t1_done_id", 0, 1'b0);
    check("t1_msg_beats", 32'(MSG_BEATS), 32'd3);
    $display("t1 single-source message: %0d beats, done ids %0d", out_q.size(), done_q.size());

    // Round-robin alternation under contention.
    do_reset(1);
    push_msg(0, 2, 16'h0A00, 16'd1);
    push_msg(0, 2, 16'h0C00, 16'd1);
    push_msg(1, 2, 16'h0B00, 16'd1);
    wait_done("t2_done_count", 3, 120);
    check_done_id("t2_order0", 0, 1'b0);
    check_done_id("t2_order1", 1, 1'b1);
    check_done_id("t2_order2", 2, 1'b0);
    check_out("t2_beat0", 0, 1'b0, 16'h0A00);
    check_out("t2_beat2", 2, 1'b1, 16'h0B00);
    check_out("t2_beat5", 5, 1'b0, 16'h0C01);
    $display("t2 round-robin: %0d beats, %0d digests", out_q.size(), done_q.size());

    // Second requester held off until the first message's digest.
    do_reset(1);
    push_msg(0, 4, 16'h3000, 16'd1);
    tick();
    push_msg(1, 2, 16'h4000, 16'd1);
    core_lat = 3;
    wait_done("t3_done_count", 2, 120);
    check("t3_s1_ready_held", 32'(rdy1_early), 32'd0);
    check("t3_grant_latency", 32'(first1_cyc - first_done_cyc), 32'd2);
    check_done_id("t3_done0", 0, 1'b0);
    check_done_id("t3_done1", 1, 1'b1);
    $display("t3 held-off grant: latency %0d cycles", first1_cyc - first_done_cyc);

    // Toggling M_TREADY: nothing lost or duplicated.
    do_reset(1);
    mrdy_mode = 2;
    push_msg(0, 4, 16'h5000, 16'h0101);
    wait_done("t4_done_count", 1, 60);
    check("t4_out_count", 32'(out_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) check_out("t4_beat", k, 1'b0, DW'(16'h5000 + 16'h0101 * k));
    check("t4_msg_beats", 32'(MSG_BEATS), 32'd4);
    $display("t4 toggled ready: %0d beats counted %0d", out_q.size(), MSG_BEATS);

    // CORE_DONE while idle sets sticky ERR.
    do_reset(1);
    spur_done = 1'b1;
    tick();
    tick();
    check("t5_err_set", 32'(ERR), 32'd1);
    check("t5_idle", 32'(BUSY), 32'd0);
    repeat (5) tick();
    check("t5_err_sticky", 32'(ERR), 32'd1);
    check("t5_no_done", 32'(done_q.size()), 32'd0);
    $display("t5 spurious done: ERR=%0d", ERR);

    // Reset during the second beat discards the message.
    do_reset(1);
    push_msg(0, 3, 16'h6000, 16'd1);
    for (int c = 0; c < 20 && out_q.size() < 1; c++) tick();
    check("t6_first_beat", 32'(out_q.size()), 32'd1);
    #3;
    ARESET = 1'b1;
    #1;
    check("t6_rst_m_tvalid", 32'(M_TVALID), 32'd0);
    check("t6_rst_s_tready", 32'(S_TREADY), 32'd0);
    check("t6_rst_busy", 32'(BUSY), 32'd0);
    check("t6_rst_msg_beats", 32'(MSG_BEATS), 32'd0);
    check("t6_rst_m_tlast", 32'(M_TLAST), 32'd0);
    do_reset(0);
    push_msg(1, 2, 16'h7000, 16'd1);
    wait_done("t6_done_count", 1, 60);
    check_done_id("t6_done_id", 0, 1'b1);
    check_out("t6_beat0", 0, 1'b1, 16'h7000);
    check_out("t6_beat1", 1, 1'b1, 16'h7001);
    $display("t6 reset mid-message: %0d digests after release", done_q.size());

    // Randomized traffic, back-pressure, valid gaps and rare stray digests.
    do_reset(0);
    gap_pct = 25;
    mrdy_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      if (src_q0.size() == 0 && $urandom_range(0, 7) == 0)
        push_msg(0, int'($urandom_range(1, 6)), DW'($urandom), 16'd1);
      if (src_q1.size() == 0 && $urandom_range(0, 7) == 0)
        push_msg(1, int'($urandom_range(1, 6)), DW'($urandom), 16'd1);
      if (m_phase != 2) core_lat = int'($urandom_range(0, 3));
      if (m_phase != 2 && $urandom_range(0, 499) == 0) spur_done = 1'b1;
      tick();
    end
    check("rand_progress", 32'(done_q.size() > 20), 32'd1);
    $display("random run: %0d beats, %0d digests", out_q.size(), done_q.size());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
